// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver with 16x oversampling and 2-of-3 majority bit decisions.
// The serial input is synchronised through two flops; everything else works
// on the synchronised copy. A free-running divider produces one tick every DIV
// system clocks, and a 4-bit sample counter splits each bit into 16 ticks.
// Samples taken at counts 7, 8 and 9 are voted to decide the bit value.
//
// Parameters
//   DIV        system clocks per 1/16 bit period (2..65535)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   rx         asynchronous serial line, idles high, 8N1, LSB first
//   rx_ready   one-clock pulse: a new correctly framed byte is on rx_data
//   rx_data    last correctly framed byte, held until the next one
//   frame_err  one-clock pulse: stop bit sampled low, byte discarded
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned DIV = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        StWaitHigh,
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic [15:0] TickMax = 16'(DIV - 1);

    // -------------------------------------------------------------------------
    // Input synchroniser. Both flops reset high so a reset never looks like a
    // start edge.
    // -------------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e      state_q,     state_d;
    logic [15:0] tick_cnt_q,  tick_cnt_d;
    logic [3:0]  s_q,         s_d;
    logic [1:0]  samp_q,      samp_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  rx_data_q,   rx_data_d;
    logic        rx_ready_q,  rx_ready_d;
    logic        frame_err_q, frame_err_d;

    logic tick;
    logic in_frame;
    logic sample_point;
    logic bit_end;
    logic maj;

    assign tick     = (tick_cnt_q == TickMax);
    assign in_frame = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

    // The vote is only meaningful on the s=9 tick: samp_q then holds the s=7
    // and s=8 samples and rxs_q is the s=9 sample.
    assign sample_point = tick && (s_q == 4'd9);
    assign bit_end      = tick && (s_q == 4'd15);
    assign maj          = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? 16'd0 : tick_cnt_q + 16'd1;
        s_d         = s_q;
        samp_d      = samp_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_ready_d  = 1'b0;
        frame_err_d = 1'b0;

        if (in_frame && tick) begin
            s_d = s_q + 4'd1;
            if (s_q == 4'd7) begin
                samp_d[0] = rxs_q;
            end
            if (s_q == 4'd8) begin
                samp_d[1] = rxs_q;
            end
        end

        unique case (state_q)
            StWaitHigh: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end

            StIdle: begin
                // Align the bit grid to the falling edge of the start bit.
                if (!rxs_q) begin
                    state_d    = StStart;
                    s_d        = 4'd0;
                    tick_cnt_d = 16'd0;
                end
            end

            StStart: begin
                if (sample_point && maj) begin
                    // Too short to be a start bit: treat as line noise.
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                end
            end

            StData: begin
                if (sample_point) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end

            StStop: begin
                // Decide mid stop bit so a start bit that follows immediately
                // is caught on its own falling edge.
                if (sample_point) begin
                    if (maj) begin
                        rx_data_d  = shift_q;
                        rx_ready_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        // Break or bad framing: wait for the line to return high.
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end
            end

            default: begin
                state_d = StWaitHigh;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StWaitHigh;
            tick_cnt_q  <= 16'd0;
            s_q         <= 4'd0;
            samp_q      <= 2'b00;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            s_q         <= s_d;
            samp_q      <= samp_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;

`ifndef SYNTHESIS
    // The two status pulses are mutually exclusive and single-cycle.
    a_no_ready_and_err : assert property (@(posedge clk) !(rx_ready && frame_err));
    a_ready_one_clk    : assert property (@(posedge clk) disable iff (reset)
                                          rx_ready |=> !rx_ready);
    a_err_one_clk      : assert property (@(posedge clk) disable iff (reset)
                                          frame_err |=> !frame_err);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Scoreboard bench for uart_rx with DIV=4 (64 clocks per bit). The stimulus
// side pushes the expected outcome of every frame it drives (byte on a valid
// stop bit, framing error otherwise, nothing for rejected glitches); a monitor
// pops one entry per rx_ready/frame_err pulse and compares.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DIV      = 4;
    localparam int BIT_CLKS = 16 * DIV;
    localparam int LATENCY  = 2 + (9 * 16 + 10) * DIV + 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       frame_err;

    uart_rx #(.DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_last       = 8'h00;
    int         n_checks       = 0;
    int         n_pass         = 0;
    int         cyc            = 0;
    int         start_cyc      = 0;
    int         last_pulse_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Drive rx for one clock, changing just after the rising edge.
    task automatic drv(input logic v);
        rx = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b1);
    endtask

    // gmode: 0 clean, 1 one-clock inversion at the s=8 sample point of every
    // data bit, 2 one-clock inversion at a random point of every data bit.
    task automatic send(input logic [7:0] b, input bit stop_hi, input int gmode,
                        input int low_extra);
        logic [9:0] fr;
        int         goff;
        exp_t       e;
        e.is_err = !stop_hi;
        e.data   = stop_hi ? b : 8'h00;
        exp_q.push_back(e);
        fr        = {stop_hi, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            goff = (gmode == 1) ? 36 : int'($urandom_range(4, 60));
            for (int c = 0; c < BIT_CLKS; c++) begin
                logic v;
                v = fr[i];
                if (gmode != 0 && i >= 1 && i <= 8 && c == goff) v = ~v;
                drv(v);
            end
        end
        if (!stop_hi) begin
            for (int c = 0; c < low_extra; c++) drv(1'b0);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 4000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check(rx_ready == 1'b0, {tag, "_rx_ready"}, int'(rx_ready), 0);
        check(frame_err == 1'b0, {tag, "_frame_err"}, int'(frame_err), 0);
        check(rx_data == 8'h00, {tag, "_rx_data"}, int'(rx_data), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one scoreboard entry per output pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_last = 8'h00;
            end else if (rx_ready || frame_err) begin
                last_pulse_cyc = cyc;
                check(!(rx_ready && frame_err), "ready_and_err_together",
                      int'({rx_ready, frame_err}), 0);
                check(exp_q.size() != 0, "pulse_expected", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        check(frame_err == 1'b1, "err_pulse_kind", int'(frame_err), 1);
                        check(rx_data == exp_last, "data_held_on_err", int'(rx_data),
                              int'(exp_last));
                    end else begin
                        check(rx_ready == 1'b1, "ready_pulse_kind", int'(rx_ready), 1);
                        check(rx_data == e.data, "rx_data", int'(rx_data), int'(e.data));
                        exp_last = e.data;
                    end
                end
            end
        end
    end

    initial begin
        bit   stop_hi;
        int   lat;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset");

        // Clean frame and its latency from the start edge.
        idle(20);
        send(8'h55, 1'b1, 0, 0);
        idle(30);
        lat = last_pulse_cyc - start_cyc;
        check(lat >= LATENCY - DIV && lat <= LATENCY + DIV, "latency", lat, LATENCY);

        // Bad stop bit followed by a long break, then a good frame.
        send(8'h0F, 1'b0, 0, 200);
        idle(30);
        send(8'h21, 1'b1, 0, 0);
        idle(20);

        // Short low pulse in idle must not start a frame.
        for (int i = 0; i < 20; i++) drv(1'b0);
        idle(100);
        send(8'hA3, 1'b1, 0, 0);
        idle(20);

        // Back-to-back frames with no idle gap.
        send(8'h01, 1'b1, 0, 0);
        send(8'h13, 1'b1, 0, 0);
        idle(30);

        // Single-clock low glitch at the centre sample of every data bit.
        send(8'hFF, 1'b1, 1, 0);
        idle(30);
        wait_drain();

        // Reset in the middle of data bit 4 of 0xFF.
        for (int i = 0; i < BIT_CLKS; i++) drv(1'b0);
        for (int i = 0; i < 4 * BIT_CLKS + 30; i++) drv(1'b1);
        reset = 1'b1;
        drv(1'b1);
        drv(1'b1);
        reset = 1'b0;
        check_reset_outputs("mid_frame_reset");
        idle(200);
        send(8'h04, 1'b1, 0, 0);
        idle(30);

        // Randomised frames: random bytes, glitches, bad stops and gaps.
        for (int n = 0; n < 14; n++) begin
            stop_hi = ($urandom_range(0, 3) != 0);
            send(8'($urandom), stop_hi, 2, int'($urandom_range(0, 150)));
            if (!(stop_hi && $urandom_range(0, 1) == 0)) idle(int'($urandom_range(16, 80)));
        end
        idle(40);
        wait_drain();
        check(rx_data == exp_last, "final_rx_data", int'(rx_data), int'(exp_last));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
